mnist_frame_deserializer: RTL

Receive side of the 16x16 binary-image byte stream that feeds the LGN MNIST classifier. The block accepts image bytes, two bytes per row and 32 bytes per frame, and assembles them into a complete 256-pixel frame. It presents each finished frame in a double-buffered register together with its set-pixel count. On the FPGA board it sits between the host/pattern source and the classifier wrapper, so inference only ever sees whole, consistent frames.

---
 rtl/mnist_pkg.sv | 21 ++
 rtl/mnist_frame_deserializer_if.sv | 24 ++
 rtl/popcount8.sv | 14 +
 rtl/mnist_frame_deserializer.sv | 121 ++++++++++++
 4 files changed

// File: rtl/mnist_pkg.sv
// Shared constants, FSM state type and pixel indexing for the LGN MNIST frame path.
package mnist_pkg;

  localparam int unsigned IMG_W           = 16;
  localparam int unsigned IMG_H           = 16;
  localparam int unsigned PIXELS          = IMG_W * IMG_H;
  localparam int unsigned BYTES_PER_FRAME = PIXELS / 8;
  localparam int unsigned IDX_W           = 5;
  localparam int unsigned COUNT_W         = 9;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  // Bit position of pixel (row, col) in a frame vector; row 0 col 0 is the MSB.
  function automatic logic [7:0] pixel_bit(input logic [3:0] row, input logic [3:0] col);
    return 8'(PIXELS - 1 - (IMG_W * int'(row) + int'(col)));
  endfunction

endpackage

// File: rtl/mnist_frame_deserializer_if.sv
// Byte-in / frame-out bundle between the pattern source and the frame deserializer.
interface mnist_frame_deserializer_if;
  import mnist_pkg::*;

  logic [7:0]         in_byte;
  logic               in_valid;
  logic               frame_start;
  logic [PIXELS-1:0]  frame;
  logic               frame_valid;
  logic [COUNT_W-1:0] pixel_count;
  logic [IDX_W-1:0]   byte_index;
  logic               sync_err;

  modport master (
    output in_byte, in_valid, frame_start,
    input  frame, frame_valid, pixel_count, byte_index, sync_err
  );

  modport slave (
    input  in_byte, in_valid, frame_start,
    output frame, frame_valid, pixel_count, byte_index, sync_err
  );

endinterface

// File: rtl/popcount8.sv
// Number of set bits in a byte (0..8).
module popcount8 (
  input  logic [7:0] data,
  output logic [3:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < 8; i++) begin
      count = count + 4'(data[i]);
    end
  end

endmodule

// File: rtl/mnist_frame_deserializer.sv
// Assembles 32 image bytes into a 256-pixel frame and publishes it, with its
// set-pixel count, only when the whole frame has arrived.
module mnist_frame_deserializer #(
  parameter int unsigned BYTES_PER_FRAME = 32,
  parameter bit          FREE_RUN        = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  mnist_frame_deserializer_if.slave  bus
);
  import mnist_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(BYTES_PER_FRAME - 1);
  localparam state_t           RESET_STATE = FREE_RUN ? FILL : IDLE;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [PIXELS-1:0]  asm_q, asm_d;
  logic [PIXELS-1:0]  frame_q, frame_d;
  logic [COUNT_W-1:0] sum_q, sum_d;
  logic [COUNT_W-1:0] pcount_q, pcount_d;
  logic               fv_q, fv_d;
  logic               se_q, se_d;

  logic [3:0]         byte_ones;
  logic               restart;
  logic               accept;
  logic [IDX_W-1:0]   slot;
  logic [7:0]         slot_lsb;

  popcount8 u_popcount8 (
    .data  (bus.in_byte),
    .count (byte_ones)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RESET_STATE;
      idx_q    <= '0;
      asm_q    <= '0;
      frame_q  <= '0;
      sum_q    <= '0;
      pcount_q <= '0;
      fv_q     <= 1'b0;
      se_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      asm_q    <= asm_d;
      frame_q  <= frame_d;
      sum_q    <= sum_d;
      pcount_q <= pcount_d;
      fv_q     <= fv_d;
      se_q     <= se_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    asm_d    = asm_q;
    frame_d  = frame_q;
    sum_d    = sum_q;
    pcount_d = pcount_q;
    fv_d     = 1'b0;
    se_d     = 1'b0;
    accept   = 1'b0;
    slot     = idx_q;
    restart  = bus.in_valid & bus.frame_start & ~FREE_RUN;

    unique case (state_q)
      IDLE: begin
        if (restart) begin
          accept  = 1'b1;
          slot    = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        if (bus.in_valid) begin
          accept = 1'b1;
          // A start marker inside a partial frame (including on the last byte) aborts it.
          if (restart && (idx_q != '0)) begin
            slot = '0;
            se_d = 1'b1;
          end
        end
      end
    endcase

    slot_lsb = {3'(LAST_IDX - slot), 3'b000} << 2'd0;
    slot_lsb = {5'(LAST_IDX - slot), 3'b000};

    if (accept) begin
      asm_d[slot_lsb +: 8] = bus.in_byte;
      if (slot == '0) begin
        sum_d = COUNT_W'(byte_ones);
      end else begin
        sum_d = sum_q + COUNT_W'(byte_ones);
      end

      if (slot == LAST_IDX) begin
        frame_d  = asm_d;
        pcount_d = sum_d;
        fv_d     = 1'b1;
        idx_d    = '0;
        sum_d    = '0;
        state_d  = FREE_RUN ? FILL : IDLE;
      end else begin
        idx_d = IDX_W'(slot + 1'b1);
      end
    end
  end

  assign bus.frame       = frame_q;
  assign bus.frame_valid = fv_q;
  assign bus.pixel_count = pcount_q;
  assign bus.byte_index  = idx_q;
  assign bus.sync_err    = se_q;

endmodule
